cc_speedcounter: RTL

Speed time-base counter driving the level speed comparator. Keeps a free-running 23-bit count, publishes it and the current level to the comparator, consumes the comparator's active-low terminal flag, then restarts the count and emits a one-cycle game tick. Level changes are requested by the game controller and take effect only on a period boundary, so a tick period is never truncated. Sits between the level/game FSM and the road-scroll and enemy-motion logic.

---
 rtl/cc_speed_pkg.sv | 26 ++
 rtl/cc_speedcounter_if.sv | 45 ++++
 rtl/cc_speedcounter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cc_speed_pkg.sv
// ---------------------------------------------------------------------------
// cc_speed_pkg
// Shared constants for the speed time-base: data/level/tick widths, the
// level codes understood by the speed comparator, and the encoding of the
// cc_speedcounter control FSM.
// ---------------------------------------------------------------------------
package cc_speed_pkg;

    localparam int SPEEDCOUNTER_DATAWIDTH  = 23;
    localparam int SPEEDCOUNTER_LEVELWIDTH = 3;
    localparam int SPEEDCOUNTER_TICKWIDTH  = 8;

    // Level codes; any other code passes through and the comparator
    // treats it as its default threshold.
    localparam logic [SPEEDCOUNTER_LEVELWIDTH-1:0] LEVEL_A     = 3'd2;
    localparam logic [SPEEDCOUNTER_LEVELWIDTH-1:0] LEVEL_B     = 3'd4;
    localparam logic [SPEEDCOUNTER_LEVELWIDTH-1:0] LEVEL_C     = 3'd6;
    localparam logic [SPEEDCOUNTER_LEVELWIDTH-1:0] LEVEL_RESET = LEVEL_A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // paused, count held, level loads apply at once
        ST_RUN  = 2'd1,   // running, no level change waiting
        ST_PEND = 2'd2    // running, captured level waits for the terminal
    } speedState_t;

endpackage : cc_speed_pkg

// File: rtl/cc_speedcounter_if.sv
// ---------------------------------------------------------------------------
// cc_speedcounter_if
// Bundles the control, comparator and output signals of cc_speedcounter.
//   master : game controller / comparator side (drives Enable, T0, LevelReq,
//            LevelLoad; observes count, level, ack, tick, tick count)
//   slave  : the speed counter itself
// ---------------------------------------------------------------------------
interface cc_speedcounter_if;
    import cc_speed_pkg::*;

    logic                                CC_SPEEDCOUNTER_Enable_In;
    logic                                CC_SPEEDCOUNTER_T0_InLow;
    logic [SPEEDCOUNTER_LEVELWIDTH-1:0]  CC_SPEEDCOUNTER_LevelReq_InBUS;
    logic                                CC_SPEEDCOUNTER_LevelLoad_In;
    logic [SPEEDCOUNTER_DATAWIDTH-1:0]   CC_SPEEDCOUNTER_data_OutBUS;
    logic [SPEEDCOUNTER_LEVELWIDTH-1:0]  CC_SPEEDCOUNTER_CurrentLevel_OutBUS;
    logic                                CC_SPEEDCOUNTER_LevelAck_Out;
    logic                                CC_SPEEDCOUNTER_Tick_Out;
    logic [SPEEDCOUNTER_TICKWIDTH-1:0]   CC_SPEEDCOUNTER_TickCount_OutBUS;

    modport master (
        output CC_SPEEDCOUNTER_Enable_In,
        output CC_SPEEDCOUNTER_T0_InLow,
        output CC_SPEEDCOUNTER_LevelReq_InBUS,
        output CC_SPEEDCOUNTER_LevelLoad_In,
        input  CC_SPEEDCOUNTER_data_OutBUS,
        input  CC_SPEEDCOUNTER_CurrentLevel_OutBUS,
        input  CC_SPEEDCOUNTER_LevelAck_Out,
        input  CC_SPEEDCOUNTER_Tick_Out,
        input  CC_SPEEDCOUNTER_TickCount_OutBUS
    );

    modport slave (
        input  CC_SPEEDCOUNTER_Enable_In,
        input  CC_SPEEDCOUNTER_T0_InLow,
        input  CC_SPEEDCOUNTER_LevelReq_InBUS,
        input  CC_SPEEDCOUNTER_LevelLoad_In,
        output CC_SPEEDCOUNTER_data_OutBUS,
        output CC_SPEEDCOUNTER_CurrentLevel_OutBUS,
        output CC_SPEEDCOUNTER_LevelAck_Out,
        output CC_SPEEDCOUNTER_Tick_Out,
        output CC_SPEEDCOUNTER_TickCount_OutBUS
    );

endinterface : cc_speedcounter_if

// File: rtl/cc_speedcounter.sv
// ---------------------------------------------------------------------------
// cc_speedcounter
// Speed time-base: free-running count published to the level comparator,
// restarted on the comparator's active-low terminal flag with a one-cycle
// game tick. Level changes requested while running are held until the next
// period boundary so that no tick period is ever truncated.
//   CC_SPEEDCOUNTER_CLOCK_50     : 50 MHz system clock
//   CC_SPEEDCOUNTER_RESET_InLow  : asynchronous reset, active low
//   speedBus (slave)             : enable / T0 / level request+strobe in;
//                                  count, level, ack, tick, tick count out
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module cc_speedcounter
    import cc_speed_pkg::*;
(
    input  logic              CC_SPEEDCOUNTER_CLOCK_50,
    input  logic              CC_SPEEDCOUNTER_RESET_InLow,
    cc_speedcounter_if.slave  speedBus
);

    logic [SPEEDCOUNTER_DATAWIDTH-1:0]  countReg;
    logic [SPEEDCOUNTER_LEVELWIDTH-1:0] levelReg;
    logic [SPEEDCOUNTER_LEVELWIDTH-1:0] pendingReg;
    logic [SPEEDCOUNTER_TICKWIDTH-1:0]  tickCountReg;
    logic                               tickReg;
    logic                               ackReg;
    speedState_t                        stateReg;

    logic enable;
    logic terminal;
    logic levelLoad;
    logic [SPEEDCOUNTER_LEVELWIDTH-1:0] levelReq;

    assign enable    = speedBus.CC_SPEEDCOUNTER_Enable_In;
    assign levelLoad = speedBus.CC_SPEEDCOUNTER_LevelLoad_In;
    assign levelReq  = speedBus.CC_SPEEDCOUNTER_LevelReq_InBUS;
    // T0 is only meaningful while counting; when paused it is ignored.
    assign terminal  = enable && !speedBus.CC_SPEEDCOUNTER_T0_InLow;

    always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or negedge CC_SPEEDCOUNTER_RESET_InLow) begin
        if (!CC_SPEEDCOUNTER_RESET_InLow) begin
            countReg     <= '0;
            levelReg     <= LEVEL_RESET;
            pendingReg   <= LEVEL_RESET;
            tickCountReg <= '0;
            tickReg      <= 1'b0;
            ackReg       <= 1'b0;
            stateReg     <= ST_IDLE;
        end else begin
            tickReg <= 1'b0;
            ackReg  <= 1'b0;

            // Count path: freezes at the edge where Enable is low, wraps
            // silently at all-ones unless the comparator flags terminal.
            if (enable) begin
                if (terminal) begin
                    countReg     <= '0;
                    tickReg      <= 1'b1;
                    tickCountReg <= tickCountReg + SPEEDCOUNTER_TICKWIDTH'(1);
                end else begin
                    countReg <= countReg + SPEEDCOUNTER_DATAWIDTH'(1);
                end
            end

            // Level / control FSM
            case (stateReg)
                ST_IDLE: begin
                    if (levelLoad) begin
                        levelReg <= levelReq;
                        ackReg   <= 1'b1;
                    end
                    if (enable) begin
                        stateReg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        stateReg <= ST_IDLE;
                        if (levelLoad) begin
                            levelReg <= levelReq;
                            ackReg   <= 1'b1;
                        end
                    end else if (levelLoad) begin
                        // A load coinciding with a terminal still waits for
                        // the following boundary.
                        pendingReg <= levelReq;
                        stateReg   <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!enable) begin
                        // Pausing flushes the pending level; a fresh load in
                        // the same cycle is the newest request and wins.
                        stateReg <= ST_IDLE;
                        levelReg <= levelLoad ? levelReq : pendingReg;
                        ackReg   <= 1'b1;
                    end else begin
                        if (terminal) begin
                            levelReg <= pendingReg;
                            ackReg   <= 1'b1;
                        end
                        if (levelLoad) begin
                            pendingReg <= levelReq;
                        end else if (terminal) begin
                            stateReg <= ST_RUN;
                        end
                    end
                end
                default: stateReg <= ST_IDLE;
            endcase
        end
    end

    assign speedBus.CC_SPEEDCOUNTER_data_OutBUS         = countReg;
    assign speedBus.CC_SPEEDCOUNTER_CurrentLevel_OutBUS = levelReg;
    assign speedBus.CC_SPEEDCOUNTER_LevelAck_Out        = ackReg;
    assign speedBus.CC_SPEEDCOUNTER_Tick_Out            = tickReg;
    assign speedBus.CC_SPEEDCOUNTER_TickCount_OutBUS    = tickCountReg;

endmodule : cc_speedcounter
